mp_req_sched: RTL and testbench

MP_REQ_SCHED -- requirements
Module: mp_req_sched

---
 rtl/mp_req_sched_pkg.sv | 23 ++
 rtl/mp_req_sched_if.sv | 67 ++++++
 rtl/mp_req_sched_prio_sel.sv | 54 +++++
 rtl/mp_req_sched.sv | 129 ++++++++++++
 tb/tb_mp_req_sched.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mp_req_sched_pkg.sv
// mp_pkg: shared constants for the main-pipe request scheduler.
//   CH_*            one-hot s1_channel encodings (MSHR tasks carry 000)
//   STARVE_LIM_DEF  default promotion threshold for channel A
//   req_e           bit positions of the per-requester grant vector
package mp_pkg;

    localparam logic [2:0] CH_MSHR = 3'b000;
    localparam logic [2:0] CH_A    = 3'b001;
    localparam logic [2:0] CH_B    = 3'b010;
    localparam logic [2:0] CH_C    = 3'b100;

    localparam int STARVE_LIM_DEF = 15;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        REQ_A    = 2'd0,
        REQ_B    = 2'd1,
        REQ_C    = 2'd2,
        REQ_MSHR = 2'd3
    } req_e;

endpackage

// File: rtl/mp_req_sched_if.sv
// mp_req_sched_if: request channels, pipe-side controls and s1 task outputs
// of the main-pipe scheduler.
//   <x>_valid/ready/set/tag/opcode  one request channel per x in {mshr,c,b,a}
//   mshr_id                         MSHR index carried by mshr requests
//   mshr_free, pipe_ready           allocation and pipe back-pressure inputs
//   s1_*                            task currently held in main pipe stage s1
//   stamp                           free-running cycle stamp
// master: request/pipe side (drives requests), slave: the scheduler.
interface mp_req_sched_if #(
    parameter int SET_W = 7,
    parameter int TAG_W = 8
);
    logic             mshr_valid, mshr_ready;
    logic [SET_W-1:0] mshr_set;
    logic [TAG_W-1:0] mshr_tag;
    logic [2:0]       mshr_opcode;
    logic [7:0]       mshr_id;

    logic             c_valid, c_ready;
    logic [SET_W-1:0] c_set;
    logic [TAG_W-1:0] c_tag;
    logic [2:0]       c_opcode;

    logic             b_valid, b_ready;
    logic [SET_W-1:0] b_set;
    logic [TAG_W-1:0] b_tag;
    logic [2:0]       b_opcode;

    logic             a_valid, a_ready;
    logic [SET_W-1:0] a_set;
    logic [TAG_W-1:0] a_tag;
    logic [2:0]       a_opcode;

    logic             mshr_free;
    logic             pipe_ready;

    logic             s1_valid;
    logic [2:0]       s1_channel;
    logic             s1_mshr_task;
    logic [7:0]       s1_mshr_id;
    logic [SET_W-1:0] s1_set;
    logic [TAG_W-1:0] s1_tag;
    logic [2:0]       s1_opcode;
    logic [63:0]      stamp;

    modport master (
        output mshr_valid, mshr_set, mshr_tag, mshr_opcode, mshr_id,
        output c_valid, c_set, c_tag, c_opcode,
        output b_valid, b_set, b_tag, b_opcode,
        output a_valid, a_set, a_tag, a_opcode,
        output mshr_free, pipe_ready,
        input  mshr_ready, c_ready, b_ready, a_ready,
        input  s1_valid, s1_channel, s1_mshr_task, s1_mshr_id,
        input  s1_set, s1_tag, s1_opcode, stamp
    );

    modport slave (
        input  mshr_valid, mshr_set, mshr_tag, mshr_opcode, mshr_id,
        input  c_valid, c_set, c_tag, c_opcode,
        input  b_valid, b_set, b_tag, b_opcode,
        input  a_valid, a_set, a_tag, a_opcode,
        input  mshr_free, pipe_ready,
        output mshr_ready, c_ready, b_ready, a_ready,
        output s1_valid, s1_channel, s1_mshr_task, s1_mshr_id,
        output s1_set, s1_tag, s1_opcode, stamp
    );
endinterface

// File: rtl/mp_req_sched_prio_sel.sv
// mp_prio_sel: combinational grant selection for the main-pipe scheduler.
//   inputs : pipe_ready, mshr_free, per-requester valids, A/B set indices,
//            in-flight s1/s2 (valid, set), a_first (A promoted over B)
//   outputs: grant (one-hot over req_e, zero when nothing issues),
//            a_elig (A passes the mshr_free and set-conflict checks)
module mp_prio_sel
    import mp_pkg::*;
#(
    parameter int SET_W = 7
) (
    input  logic             pipe_ready,
    input  logic             mshr_free,
    input  logic             mshr_valid,
    input  logic             c_valid,
    input  logic             b_valid,
    input  logic             a_valid,
    input  logic [SET_W-1:0] b_set,
    input  logic [SET_W-1:0] a_set,
    input  logic             s1_valid,
    input  logic [SET_W-1:0] s1_set,
    input  logic             s2_valid,
    input  logic [SET_W-1:0] s2_set,
    input  logic             a_first,
    output logic [N_REQ-1:0] grant,
    output logic             a_elig
);

    logic b_elig;
    logic a_req;
    logic b_req;

    // A set already in s1 or s2 must not be re-entered until it drains.
    function automatic logic set_busy(input logic [SET_W-1:0] set,
                                      input logic s1_v, input logic [SET_W-1:0] s1_s,
                                      input logic s2_v, input logic [SET_W-1:0] s2_s);
        return (s1_v && (s1_s == set)) || (s2_v && (s2_s == set));
    endfunction

    always_comb begin
        a_elig = mshr_free && !set_busy(a_set, s1_valid, s1_set, s2_valid, s2_set);
        b_elig = mshr_free && !set_busy(b_set, s1_valid, s1_set, s2_valid, s2_set);
        a_req  = a_valid && a_elig;
        b_req  = b_valid && b_elig;
        grant  = '0;
        if (pipe_ready) begin
            if (mshr_valid)           grant[REQ_MSHR] = 1'b1;
            else if (c_valid)         grant[REQ_C]    = 1'b1;
            else if (a_first && a_req) grant[REQ_A]   = 1'b1;
            else if (b_req)           grant[REQ_B]    = 1'b1;
            else if (a_req)           grant[REQ_A]    = 1'b1;
        end
    end

endmodule

// File: rtl/mp_req_sched.sv
// mp_req_sched: arbitrates mshr, C, B and A requests into main pipe stage s1.
//   clock  rising-edge clock
//   reset  synchronous, active-low
//   bus    mp_req_sched_if.slave: request channels, mshr_free, pipe_ready,
//          s1_* task outputs and the free-running stamp
// One task per pipe_ready cycle; grant shows up on s1 one cycle later.
// A starvation counter promotes A above B after STARVE_LIM lost cycles.
module mp_req_sched
    import mp_pkg::*;
#(
    parameter int SET_W      = 7,
    parameter int TAG_W      = 8,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic         clock,
    input  logic         reset,
    mp_req_sched_if.slave bus
);

    logic [7:0]       starve_cnt;
    logic             shadow_vld_p2;
    logic [SET_W-1:0] shadow_set_p2;

    logic [N_REQ-1:0] sel_grant;
    logic [N_REQ-1:0] grant;
    logic             a_elig;
    logic             a_first;

    logic [2:0]       sel_channel;
    logic             sel_mshr_task;
    logic [7:0]       sel_mshr_id;
    logic [SET_W-1:0] sel_set;
    logic [TAG_W-1:0] sel_tag;
    logic [2:0]       sel_opcode;

    assign a_first = (starve_cnt == 8'(STARVE_LIM));

    mp_prio_sel #(.SET_W(SET_W)) u_prio_sel (
        .pipe_ready (bus.pipe_ready),
        .mshr_free  (bus.mshr_free),
        .mshr_valid (bus.mshr_valid),
        .c_valid    (bus.c_valid),
        .b_valid    (bus.b_valid),
        .a_valid    (bus.a_valid),
        .b_set      (bus.b_set),
        .a_set      (bus.a_set),
        .s1_valid   (bus.s1_valid),
        .s1_set     (bus.s1_set),
        .s2_valid   (shadow_vld_p2),
        .s2_set     (shadow_set_p2),
        .a_first    (a_first),
        .grant      (sel_grant),
        .a_elig     (a_elig)
    );

    // No requester may see ready while reset is held low.
    assign grant = reset ? sel_grant : '0;

    assign bus.mshr_ready = grant[REQ_MSHR];
    assign bus.c_ready    = grant[REQ_C];
    assign bus.b_ready    = grant[REQ_B];
    assign bus.a_ready    = grant[REQ_A];

    always_comb begin
        sel_channel   = CH_A;
        sel_mshr_task = 1'b0;
        sel_mshr_id   = '0;
        sel_set       = bus.a_set;
        sel_tag       = bus.a_tag;
        sel_opcode    = bus.a_opcode;
        if (grant[REQ_MSHR]) begin
            sel_channel   = CH_MSHR;
            sel_mshr_task = 1'b1;
            sel_mshr_id   = bus.mshr_id;
            sel_set       = bus.mshr_set;
            sel_tag       = bus.mshr_tag;
            sel_opcode    = bus.mshr_opcode;
        end else if (grant[REQ_C]) begin
            sel_channel = CH_C;
            sel_set     = bus.c_set;
            sel_tag     = bus.c_tag;
            sel_opcode  = bus.c_opcode;
        end else if (grant[REQ_B]) begin
            sel_channel = CH_B;
            sel_set     = bus.b_set;
            sel_tag     = bus.b_tag;
            sel_opcode  = bus.b_opcode;
        end
    end

    // s1 register / s2 shadow boundary: both advance only on pipe_ready.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.s1_valid     <= 1'b0;
            bus.s1_channel   <= '0;
            bus.s1_mshr_task <= 1'b0;
            bus.s1_mshr_id   <= '0;
            bus.s1_set       <= '0;
            bus.s1_tag       <= '0;
            bus.s1_opcode    <= '0;
            bus.stamp        <= '0;
            shadow_vld_p2    <= 1'b0;
            shadow_set_p2    <= '0;
            starve_cnt       <= '0;
        end else begin
            bus.stamp <= bus.stamp + 64'd1;
            if (bus.pipe_ready) begin
                shadow_vld_p2 <= bus.s1_valid;
                shadow_set_p2 <= bus.s1_set;
                bus.s1_valid  <= |grant;
                if (|grant) begin
                    bus.s1_channel   <= sel_channel;
                    bus.s1_mshr_task <= sel_mshr_task;
                    bus.s1_mshr_id   <= sel_mshr_id;
                    bus.s1_set       <= sel_set;
                    bus.s1_tag       <= sel_tag;
                    bus.s1_opcode    <= sel_opcode;
                end
                // Count only cycles A could have gone but lost to someone else.
                if (grant[REQ_A] || !bus.a_valid) begin
                    starve_cnt <= '0;
                end else if (a_elig && !a_first) begin
                    starve_cnt <= starve_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mp_req_sched.sv
// Testbench for mp_req_sched: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a behavioural scheduler model.
module tb_mp_req_sched;
    localparam int SET_W = 7;
    localparam int TAG_W = 8;
    localparam int LIM   = 15;

    typedef struct packed {
        logic             v;
        logic [2:0]       ch;
        logic             mt;
        logic [7:0]       id;
        logic [SET_W-1:0] set;
        logic [TAG_W-1:0] tag;
        logic [2:0]       op;
    } task_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mp_req_sched_if #(.SET_W(SET_W), .TAG_W(TAG_W)) bus ();

    mp_req_sched #(.SET_W(SET_W), .TAG_W(TAG_W), .STARVE_LIM(LIM)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: tasks that entered the pipe at the last two pipe advances
    // (newest first), the visible s1 contents, A's lost-cycle tally, stamp.
    task_t           hist[$];
    task_t           m_out = '0;
    int              lost = 0;
    longint unsigned m_stamp = 0;

    int         last_grant = -1;
    logic [3:0] obs_rdy;
    task_t      snap;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit busy(input logic [SET_W-1:0] s);
        foreach (hist[i]) if (hist[i].v && hist[i].set == s) return 1'b1;
        return 1'b0;
    endfunction

    // Returns 3=mshr, 2=c, 1=b, 0=a, -1=none.
    function automatic int model_grant(output bit ea);
        bit eb;
        bit a_req;
        bit b_req;
        ea = bus.mshr_free && !busy(bus.a_set);
        eb = bus.mshr_free && !busy(bus.b_set);
        a_req = bus.a_valid && ea;
        b_req = bus.b_valid && eb;
        if (!reset || !bus.pipe_ready) return -1;
        if (bus.mshr_valid) return 3;
        if (bus.c_valid) return 2;
        if (lost >= LIM && a_req) return 0;
        if (b_req) return 1;
        if (a_req) return 0;
        return -1;
    endfunction

    function automatic task_t task_of(input int g);
        task_t t;
        t = '0;
        t.v = 1'b1;
        case (g)
            3: begin t.ch = 3'b000; t.mt = 1'b1; t.id = bus.mshr_id;
                     t.set = bus.mshr_set; t.tag = bus.mshr_tag; t.op = bus.mshr_opcode; end
            2: begin t.ch = 3'b100; t.set = bus.c_set; t.tag = bus.c_tag; t.op = bus.c_opcode; end
            1: begin t.ch = 3'b010; t.set = bus.b_set; t.tag = bus.b_tag; t.op = bus.b_opcode; end
            default: begin t.ch = 3'b001; t.set = bus.a_set; t.tag = bus.a_tag; t.op = bus.a_opcode; end
        endcase
        return t;
    endfunction

    task automatic model_edge(input int g, input bit ea);
        if (!reset) begin
            hist.delete();
            lost    = 0;
            m_out   = '0;
            m_stamp = 0;
            return;
        end
        m_stamp++;
        if (!bus.pipe_ready) return;
        if (g < 0) m_out.v = 1'b0;
        else m_out = task_of(g);
        hist.push_front(m_out);
        if (hist.size() > 2) void'(hist.pop_back());
        if (g == 0 || !bus.a_valid) lost = 0;
        else if (ea && lost < LIM) lost++;
    endtask

    function automatic task_t dut_s1();
        return task_t'({bus.s1_valid, bus.s1_channel, bus.s1_mshr_task, bus.s1_mshr_id,
                        bus.s1_set, bus.s1_tag, bus.s1_opcode});
    endfunction

    // One clock cycle: check readys mid-cycle, then s1/stamp after the edge.
    task automatic step();
        int g;
        bit ea;
        logic [3:0] exp_rdy;
        @(negedge clk);
        g = model_grant(ea);
        exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
        obs_rdy = {bus.mshr_ready, bus.c_ready, bus.b_ready, bus.a_ready};
        chk("ready", 128'(obs_rdy), 128'(exp_rdy));
        @(posedge clk);
        model_edge(g, ea);
        last_grant = g;
        #1;
        chk("s1", 128'(dut_s1()), 128'(m_out));
        chk("stamp", 128'(bus.stamp), 128'(m_stamp));
    endtask

    task automatic set_req(input int k, input bit v, input int s);
        case (k)
            3: begin bus.mshr_valid = v; bus.mshr_set = SET_W'(s); bus.mshr_tag = TAG_W'($urandom);
                     bus.mshr_opcode = 3'($urandom); bus.mshr_id = 8'($urandom); end
            2: begin bus.c_valid = v; bus.c_set = SET_W'(s); bus.c_tag = TAG_W'($urandom);
                     bus.c_opcode = 3'($urandom); end
            1: begin bus.b_valid = v; bus.b_set = SET_W'(s); bus.b_tag = TAG_W'($urandom);
                     bus.b_opcode = 3'($urandom); end
            default: begin bus.a_valid = v; bus.a_set = SET_W'(s); bus.a_tag = TAG_W'($urandom);
                     bus.a_opcode = 3'($urandom); end
        endcase
    endtask

    function automatic bit valid_of(input int k);
        case (k)
            3: return bus.mshr_valid;
            2: return bus.c_valid;
            1: return bus.b_valid;
            default: return bus.a_valid;
        endcase
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, 0);
    endtask

    initial begin
        int bs;
        int pct[4];
        pct = '{40, 70, 15, 20};  // a, b, c, mshr
        idle_all();
        bus.mshr_free  = 1'b1;
        bus.pipe_ready = 1'b1;

        // Reset state.
        step();
        step();
        chk("rst_s1", 128'(dut_s1()), 128'(0));
        chk("rst_stamp", 128'(bus.stamp), 128'(0));
        chk("rst_rdy", 128'(obs_rdy), 128'(0));

        // All four requesters at once: only mshr gets ready.
        reset = 1'b1;
        set_req(3, 1'b1, 1); set_req(2, 1'b1, 2); set_req(1, 1'b1, 3); set_req(0, 1'b1, 4);
        step();
        chk("all4_rdy", 128'(obs_rdy), 128'(4'b1000));
        chk("all4_s1", 128'({bus.s1_valid, bus.s1_mshr_task, bus.s1_channel}), 128'(5'b11000));
        chk("all4_stamp", 128'(bus.stamp), 128'(1));
        idle_all();
        step();
        step();

        // Set conflict: B behind A on set 0x12 waits two pipe cycles.
        set_req(0, 1'b1, 'h12);
        step();
        chk("conf_a", 128'(obs_rdy), 128'(4'b0001));
        set_req(0, 1'b0, 0);
        set_req(1, 1'b1, 'h12);
        step();
        chk("conf_b1", 128'(obs_rdy), 128'(4'b0000));
        step();
        chk("conf_b2", 128'(obs_rdy), 128'(4'b0000));
        step();
        chk("conf_b3", 128'(obs_rdy), 128'(4'b0010));
        idle_all();
        step();
        step();

        // Starvation: B always present, A wins on its 16th eligible cycle.
        bs = 'h20;
        set_req(0, 1'b1, 'h05);
        for (int i = 1; i <= 16; i++) begin
            set_req(1, 1'b1, bs);
            bs++;
            step();
            chk("starve", 128'(obs_rdy), 128'((i == 16) ? 4'b0001 : 4'b0010));
        end
        set_req(0, 1'b1, 'h06);
        set_req(1, 1'b1, bs);
        bs++;
        step();
        chk("starve_clr", 128'(obs_rdy), 128'(4'b0010));

        // Pipe stall: nothing granted, s1 frozen, starvation tally frozen.
        snap = dut_s1();
        set_req(1, 1'b1, bs);
        bs++;
        bus.pipe_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_rdy", 128'(obs_rdy), 128'(0));
            chk("stall_s1", 128'(dut_s1()), 128'(snap));
        end
        bus.pipe_ready = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("stall_cnt", 128'(obs_rdy), 128'((i == 15) ? 4'b0001 : 4'b0010));
            set_req(1, 1'b1, bs);
            bs++;
        end
        idle_all();
        step();
        step();

        // No free MSHR: C goes, A and B wait for mshr_free.
        bus.mshr_free = 1'b0;
        set_req(0, 1'b1, 'h50); set_req(1, 1'b1, 'h51); set_req(2, 1'b1, 'h52);
        step();
        chk("nofree_c", 128'(obs_rdy), 128'(4'b0100));
        set_req(2, 1'b0, 0);
        step();
        chk("nofree_w1", 128'(obs_rdy), 128'(0));
        step();
        chk("nofree_w2", 128'(obs_rdy), 128'(0));
        bus.mshr_free = 1'b1;
        step();
        chk("free_b", 128'(obs_rdy), 128'(4'b0010));
        set_req(1, 1'b0, 0);
        step();
        chk("free_a", 128'(obs_rdy), 128'(4'b0001));
        idle_all();

        // Mid-operation reset with s1 occupied.
        set_req(2, 1'b1, 'h60);
        step();
        chk("pre_rst_v", 128'(bus.s1_valid), 128'(1));
        reset = 1'b0;
        set_req(2, 1'b1, 'h61);
        step();
        chk("mid_rst_s1", 128'(dut_s1()), 128'(0));
        chk("mid_rst_stamp", 128'(bus.stamp), 128'(0));
        chk("mid_rst_rdy", 128'(obs_rdy), 128'(0));
        reset = 1'b1;
        step();
        chk("rel_rdy", 128'(obs_rdy), 128'(4'b0100));
        chk("rel_stamp", 128'(bus.stamp), 128'(1));
        idle_all();

        // Randomized traffic; requesters hold valid until granted.
        for (int k = 0; k < 4; k++) set_req(k, $urandom_range(0, 99) < pct[k], $urandom_range(0, 5));
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) != 0);
            bus.pipe_ready = ($urandom_range(0, 99) < 75);
            bus.mshr_free  = ($urandom_range(0, 99) < 80);
            step();
            for (int k = 0; k < 4; k++)
                if (last_grant == k || !valid_of(k))
                    set_req(k, $urandom_range(0, 99) < pct[k], $urandom_range(0, 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
